hall_call_scheduler: RTL
========================

// Module: hall_call_scheduler
// PURPOSE
// - Latches hall-call buttons (up/dn per floor) and holds them as pending calls.
// - Presents unassigned calls one at a time to building_dispatcher (request_floor/request_dir).
// - Records which elevator was dispatched to each call; clears the call when that elevator opens its doors there.
// - Sits between the hall button panel and building_dispatcher; drives the hall lamps.
// PARAMETERS
// - NUM_FLOORS       8   floors in building; valid floors 0..NUM_FLOORS-1
// - FLOOR_W          3   floor index width, $clog2(NUM_FLOORS)
// - DISPATCH_TIMEOUT 15  cycles to wait for a dispatch decision before skipping the call
// PORTS
// - clk                   in   1           system clock, rising edge
// - rst                   in   1           synchronous, active-high reset
// - hall_up_btn           in   NUM_FLOORS  level; bit f = up button at floor f
// - hall_dn_btn           in   NUM_FLOORS  level; bit f = down button at floor f
// - request_floor         out  FLOOR_W     floor of presented call (to dispatcher)
// - request_dir           out  1           1=up, 0=down, presented call
// - request_valid         out  1           presented call is valid
// - dispatch_elev_1       in   1           dispatcher selects elevator 1 for presented call
// - dispatch_elev_2       in   1           dispatcher selects elevator 2 for presented call
// - door_open_elev_1      in   1           1-cycle pulse: elevator 1 opened doors
// - door_open_elev_2      in   1           1-cycle pulse: elevator 2 opened doors
// - current_floor_elev_1  in   FLOOR_W     elevator 1 floor, sampled with door_open
// - current_floor_elev_2  in   FLOOR_W     elevator 2 floor, sampled with door_open
// - current_dir_elev_1    in   1           elevator 1 direction, sampled with door_open
// - current_dir_elev_2    in   1           elevator 2 direction, sampled with door_open
// - pending_up            out  NUM_FLOORS  up-lamp per floor (call pending)
// - pending_dn            out  NUM_FLOORS  down-lamp per floor (call pending)
// BEHAVIOUR
// - Reset: request_floor=0, request_dir=0, request_valid=0, pending_up/dn=0, all assignments cleared, FSM=IDLE, scan pointer=0, timer=0.
// - Call slots: 2*NUM_FLOORS; slot s<NUM_FLOORS is up at floor s, else down at floor s-NUM_FLOORS.
// - Slot state per call: EMPTY -> PENDING (button seen) -> ASSIGNED_1 / ASSIGNED_2 -> EMPTY (cleared).
// - Button press sets PENDING next cycle if slot EMPTY; ignored if already PENDING/ASSIGNED.
// - Up at top floor and down at floor 0 ignored; those lamps stay 0.
// - pending_up/dn bit = slot not EMPTY (registered, 1-cycle after press).
// - Clear: door_open_elev_k pulse clears the slot (current_floor_elev_k, current_dir_elev_k) if it is assigned to elevator k or PENDING.
//   A slot assigned to the other elevator is left untouched.
// - Clear and press on same slot, same cycle: clear wins (car is there, call serviced).
// - Both elevators clear same cycle: both slots cleared independently.
// - FSM IDLE: round-robin search of PENDING slots starting at scan pointer+1 (wraps at 2*NUM_FLOORS-1 -> 0).
//   On a hit: load request_floor/dir, request_valid=1, go PRESENT, timer=0.
// - FSM PRESENT: request outputs held stable. dispatch_elev_1 -> slot ASSIGNED_1; else dispatch_elev_2 -> ASSIGNED_2 (elev 1 wins if both).
//   On assignment: request_valid=0, scan pointer=slot, go IDLE.
// - PRESENT, timer reaches DISPATCH_TIMEOUT: request_valid=0, slot stays PENDING, scan pointer=slot, go IDLE (fairness: next slot searched first).
// - PRESENT, presented slot cleared by door_open: request_valid=0 next cycle, no assignment, go IDLE.
// - Latency: press -> request_valid >=2 cycles (1 latch, 1 search); dispatch -> request_valid low next cycle; min 1 IDLE cycle between requests.
// - rst asserted mid-PRESENT: all state returns to reset values next edge; pending calls lost.
// STRUCTURE
// - elevator_pkg: typedef enum {SLOT_EMPTY, SLOT_PENDING, SLOT_ASSIGNED_1, SLOT_ASSIGNED_2} slot_state_t;
//   typedef enum {SCHED_IDLE, SCHED_PRESENT} sched_state_t; constants DIR_UP=1, DIR_DN=0, NUM_FLOORS, FLOOR_W.
// - Sub-module hall_call_rr_picker: combinational round-robin priority encoder (mask + ptr -> hit, slot index).
// TESTING
// - Reset then idle: pending_up/dn=0, request_valid=0 for 20 cycles.
// - hall_up_btn[3] 1 cycle -> pending_up[3]=1; request_floor=3, dir=1, valid; dispatch_elev_2 -> valid drops; door_open_elev_2 at floor 3 up -> pending_up[3]=0.
// - Calls up@1, dn@5, up@6 simultaneous; dispatch each on first valid cycle -> presented in order 1,6,5 (up slots before dn) with 1 idle cycle between.
// - up@2 presented, no dispatch for 15 cycles -> valid drops, next pending (dn@4) presented; up@2 re-presented after wrap.
// - up@4 assigned to elev 1; door_open_elev_2 at 4 up -> pending_up[4] stays 1; door_open_elev_1 at 4 up -> cleared.
// - hall_up_btn[7] and hall_dn_btn[0] -> no lamp, no request; rst during PRESENT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and constants for the hall-call scheduling slice.
//   slot_state_t  : life cycle of one hall call (floor + direction)
//   sched_state_t : presenter FSM states
//   slot helpers  : map between slot index and (floor, direction)
package elevator_pkg;

  localparam int unsigned NUM_FLOORS               = 8;
  localparam int unsigned FLOOR_W                  = $clog2(NUM_FLOORS);
  localparam int unsigned NUM_SLOTS                = 2 * NUM_FLOORS;
  localparam int unsigned SLOT_W                   = $clog2(NUM_SLOTS);
  localparam int unsigned DEFAULT_DISPATCH_TIMEOUT = 15;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    SLOT_EMPTY,
    SLOT_PENDING,
    SLOT_ASSIGNED_1,
    SLOT_ASSIGNED_2
  } slot_state_t;

  typedef enum logic {
    SCHED_IDLE,
    SCHED_PRESENT
  } sched_state_t;

  // Up calls occupy slots 0..NUM_FLOORS-1, down calls the upper half.
  function automatic logic [SLOT_W-1:0] slot_of(input logic [FLOOR_W-1:0] floor,
                                                 input logic              dir);
    if (dir == DIR_UP) return SLOT_W'(floor);
    return SLOT_W'(floor) + SLOT_W'(NUM_FLOORS);
  endfunction

  function automatic logic [FLOOR_W-1:0] slot_floor(input logic [SLOT_W-1:0] slot);
    if (slot >= SLOT_W'(NUM_FLOORS)) return FLOOR_W'(slot - SLOT_W'(NUM_FLOORS));
    return FLOOR_W'(slot);
  endfunction

  function automatic logic slot_dir(input logic [SLOT_W-1:0] slot);
    return (slot < SLOT_W'(NUM_FLOORS)) ? DIR_UP : DIR_DN;
  endfunction

endpackage

// File: rtl/hall_call_rr_picker.sv
// Combinational round-robin priority encoder over the pending-call mask.
// Search order is ptr+1, ptr+2, ... wrapping, with ptr itself checked last,
// so the most recently served slot has the lowest priority.
//   mask_i   : one bit per call slot that may be presented
//   ptr_i    : last slot served
//   hit_c_o  : some slot in mask_i is set
//   slot_c_o : first set slot in search order (0 when no hit)
module hall_call_rr_picker
  import elevator_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] mask_i,
  input  logic [SLOT_W-1:0]    ptr_i,
  output logic                 hit_c_o,
  output logic [SLOT_W-1:0]    slot_c_o
);

  localparam int unsigned SUM_W = SLOT_W + 1;

  logic [SUM_W-1:0]  sum;
  logic [SLOT_W-1:0] cand;

  // Walk all offsets in priority order; the first set slot wins.
  always_comb begin
    hit_c_o  = 1'b0;
    slot_c_o = '0;
    sum      = '0;
    cand     = '0;
    for (int unsigned off = 1; off <= NUM_SLOTS; off++) begin
      sum = {1'b0, ptr_i} + SUM_W'(off);
      if (sum >= SUM_W'(NUM_SLOTS)) sum = sum - SUM_W'(NUM_SLOTS);
      cand = SLOT_W'(sum);
      if (!hit_c_o && mask_i[cand]) begin
        hit_c_o  = 1'b1;
        slot_c_o = cand;
      end
    end
  end

endmodule

// File: rtl/hall_call_scheduler.sv
// Hall-call scheduler: latches hall buttons into per-call slots, presents
// pending calls one at a time to the building dispatcher, remembers which
// car took each call and clears it when that car opens its doors there.
//   clk, rst                       : clock, synchronous active-high reset
//   hall_up_btn / hall_dn_btn      : level button inputs, bit f = floor f
//   request_floor/dir/valid        : call currently offered to dispatcher
//   dispatch_elev_1/2              : dispatcher picks a car for that call
//   door_open_elev_1/2             : one-cycle door-open pulse per car
//   current_floor/dir_elev_1/2     : car position, valid with door_open
//   pending_up / pending_dn        : hall lamps, one bit per floor
module hall_call_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned DISPATCH_TIMEOUT = DEFAULT_DISPATCH_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] hall_up_btn,
  input  logic [NUM_FLOORS-1:0] hall_dn_btn,
  output logic [FLOOR_W-1:0]    request_floor,
  output logic                  request_dir,
  output logic                  request_valid,
  input  logic                  dispatch_elev_1,
  input  logic                  dispatch_elev_2,
  input  logic                  door_open_elev_1,
  input  logic                  door_open_elev_2,
  input  logic [FLOOR_W-1:0]    current_floor_elev_1,
  input  logic [FLOOR_W-1:0]    current_floor_elev_2,
  input  logic                  current_dir_elev_1,
  input  logic                  current_dir_elev_2,
  output logic [NUM_FLOORS-1:0] pending_up,
  output logic [NUM_FLOORS-1:0] pending_dn
);

  // Timer counts 0..DISPATCH_TIMEOUT-1 while a call is on offer.
  localparam int unsigned TIMER_W = (DISPATCH_TIMEOUT > 2) ? $clog2(DISPATCH_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DISPATCH_TIMEOUT - 1);

  sched_state_t        state_q;
  logic [SLOT_W-1:0]   ptr_q;
  logic [SLOT_W-1:0]   cur_slot_q;
  logic [TIMER_W-1:0]  timer_q;

  logic [NUM_SLOTS-1:0] press;
  logic [NUM_SLOTS-1:0] clear;
  logic [NUM_SLOTS-1:0] pend_mask;
  logic [NUM_SLOTS-1:0] busy_d;
  logic [SLOT_W-1:0]    clr1_slot;
  logic [SLOT_W-1:0]    clr2_slot;
  logic                 cur_cleared;
  logic                 take_disp;
  slot_state_t          disp_state;
  logic                 pick_hit;
  logic [SLOT_W-1:0]    pick_slot;

  // Button-to-slot mapping; up at the top floor and down at floor 0 do not exist.
  for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_press
    assign press[f]              = hall_up_btn[f] && (f != NUM_FLOORS - 1);
    assign press[f + NUM_FLOORS] = hall_dn_btn[f] && (f != 0);
  end

  assign clr1_slot = slot_of(current_floor_elev_1, current_dir_elev_1);
  assign clr2_slot = slot_of(current_floor_elev_2, current_dir_elev_2);

  // A presented call that is cleared this cycle must not be handed out.
  assign cur_cleared = clear[cur_slot_q];
  assign take_disp   = (state_q == SCHED_PRESENT) && !cur_cleared &&
                       (dispatch_elev_1 || dispatch_elev_2);
  assign disp_state  = dispatch_elev_1 ? SLOT_ASSIGNED_1 : SLOT_ASSIGNED_2;

  // Per-slot call state: clear beats dispatch beats press.
  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    slot_state_t st_q;
    slot_state_t st_d;
    logic        hit1;
    logic        hit2;

    assign hit1 = door_open_elev_1 && (clr1_slot == SLOT_W'(s));
    assign hit2 = door_open_elev_2 && (clr2_slot == SLOT_W'(s));

    assign clear[s] = (hit1 && (st_q == SLOT_PENDING || st_q == SLOT_ASSIGNED_1)) ||
                      (hit2 && (st_q == SLOT_PENDING || st_q == SLOT_ASSIGNED_2));

    // A press while a car stands at the landing is already serviced.
    always_comb begin
      st_d = st_q;
      if (clear[s]) begin
        st_d = SLOT_EMPTY;
      end else if (take_disp && (cur_slot_q == SLOT_W'(s))) begin
        st_d = disp_state;
      end else if (press[s] && !hit1 && !hit2 && (st_q == SLOT_EMPTY)) begin
        st_d = SLOT_PENDING;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) st_q <= SLOT_EMPTY;
      else     st_q <= st_d;
    end

    assign pend_mask[s] = (st_q == SLOT_PENDING);
    assign busy_d[s]    = (st_d != SLOT_EMPTY);
  end

  // Slots being cleared this cycle are excluded from the search.
  hall_call_rr_picker u_picker (
    .mask_i   (pend_mask & ~clear),
    .ptr_i    (ptr_q),
    .hit_c_o  (pick_hit),
    .slot_c_o (pick_slot)
  );

  // Presenter FSM with registered request and lamp outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SCHED_IDLE;
      ptr_q         <= '0;
      cur_slot_q    <= '0;
      timer_q       <= '0;
      request_floor <= '0;
      request_dir   <= 1'b0;
      request_valid <= 1'b0;
      pending_up    <= '0;
      pending_dn    <= '0;
    end else begin
      pending_up <= busy_d[NUM_FLOORS-1:0];
      pending_dn <= busy_d[NUM_SLOTS-1:NUM_FLOORS];
      case (state_q)
        SCHED_IDLE: begin
          if (pick_hit) begin
            cur_slot_q    <= pick_slot;
            request_floor <= slot_floor(pick_slot);
            request_dir   <= slot_dir(pick_slot);
            request_valid <= 1'b1;
            timer_q       <= '0;
            state_q       <= SCHED_PRESENT;
          end
        end
        SCHED_PRESENT: begin
          if (cur_cleared) begin
            request_valid <= 1'b0;
            state_q       <= SCHED_IDLE;
          end else if (take_disp) begin
            request_valid <= 1'b0;
            ptr_q         <= cur_slot_q;
            state_q       <= SCHED_IDLE;
          end else if (timer_q == TIMER_LAST) begin
            // Skip an unanswered call; the pointer moves past it for fairness.
            request_valid <= 1'b0;
            ptr_q         <= cur_slot_q;
            state_q       <= SCHED_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= SCHED_IDLE;
      endcase
    end
  end

endmodule
